// File: rtl/miner_pkg.sv
// Shared types and defaults for the miner link sequencer.
package miner_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        HASH = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int HEADER_BYTES = 76;
    localparam int NONCE_BYTES  = 4;
    localparam int NONCE_W      = 32;
    localparam int HASH_W       = 256;

endpackage

// File: rtl/miner_link_ctrl.sv
// Job sequencer: collects a block header from UART, runs the hashcore for a
// number of timer ticks, then sends the best nonce back MSB-first.
module miner_link_ctrl #(
    parameter int HEADER_BYTES   = miner_pkg::HEADER_BYTES,
    parameter int NONCE_BYTES    = miner_pkg::NONCE_BYTES,
    parameter int HASH_TICKS     = 1,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic                      rx_valid_i,
    input  logic [7:0]                rx_byte_i,
    output logic                      tx_start_o,
    output logic [7:0]                tx_byte_o,
    input  logic                      tx_active_i,
    input  logic                      tx_done_i,
    input  logic                      second_tick_i,
    output logic                      hash_enable_o,
    output logic                      hash_clear_o,
    output logic [8*HEADER_BYTES-1:0] block_o,
    input  logic [31:0]               best_nonce_i,
    output logic [1:0]                state_o
);
    import miner_pkg::*;

    localparam int CNT_W  = $clog2(HEADER_BYTES);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TICK_W = (HASH_TICKS > 1) ? $clog2(HASH_TICKS) : 1;
    localparam int IDX_W  = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(HEADER_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HASH_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NONCE_BYTES - 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDLE_W-1:0]         idle_q, idle_d;
    logic [TICK_W-1:0]         tick_q, tick_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      wait_q, wait_d;
    logic [NONCE_W-1:0]        nonce_q, nonce_d;
    logic                      tx_start_q, tx_start_d;
    logic [7:0]                tx_byte_q, tx_byte_d;
    logic                      hash_en_q, hash_en_d;
    logic                      hash_clr_q, hash_clr_d;
    logic [8*HEADER_BYTES-1:0] block_q, block_d;
    logic                      launch;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        tick_d     = tick_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        nonce_d    = nonce_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        hash_en_d  = hash_en_q;
        hash_clr_d = 1'b0;
        block_d    = block_q;
        launch     = 1'b0;

        case (state_q)
            RECV: begin
                if (rx_valid_i) begin
                    for (int unsigned k = 0; k < HEADER_BYTES; k++) begin
                        if (cnt_q == CNT_W'(k)) block_d[8*k +: 8] = rx_byte_i;
                    end
                    idle_d = '0;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d      = '0;
                        tick_d     = '0;
                        state_d    = HASH;
                        hash_clr_d = 1'b1;
                        hash_en_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q != '0) begin
                    // Abandon a stalled partial header; stale bytes stay in block_q.
                    if (idle_q == IDLE_LAST) begin
                        cnt_d  = '0;
                        idle_d = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            HASH: begin
                if (second_tick_i) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        nonce_d   = best_nonce_i;
                        hash_en_d = 1'b0;
                        idx_d     = '0;
                        wait_d    = 1'b0;
                        state_d   = SEND;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            SEND: begin
                // A done pulse may relaunch in the same cycle so the next start
                // follows the done with no idle gap.
                if (wait_q && tx_done_i) begin
                    wait_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = RECV;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        launch = !tx_active_i;
                    end
                end else if (!wait_q && !tx_active_i) begin
                    launch = 1'b1;
                end
                if (launch) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = nonce_q[NONCE_W-1 -: 8];
                    nonce_d    = {nonce_q[NONCE_W-9:0], 8'h00};
                    wait_d     = 1'b1;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            state_q    <= RECV;
            cnt_q      <= '0;
            idle_q     <= '0;
            tick_q     <= '0;
            idx_q      <= '0;
            wait_q     <= 1'b0;
            nonce_q    <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            hash_en_q  <= 1'b0;
            hash_clr_q <= 1'b0;
            block_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            nonce_q    <= nonce_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            hash_en_q  <= hash_en_d;
            hash_clr_q <= hash_clr_d;
            block_q    <= block_d;
        end
    end

    assign tx_start_o    = tx_start_q;
    assign tx_byte_o     = tx_byte_q;
    assign hash_enable_o = hash_en_q;
    assign hash_clear_o  = hash_clr_q;
    assign block_o       = block_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_miner_link_ctrl.sv
// Scoreboard bench for miner_link_ctrl: random header/nonce jobs against a
// byte-level job model, with an emulated UART transmitter.
module tb_miner_link_ctrl;

    localparam int HB      = 76;
    localparam int NB      = 4;
    localparam int TICKS   = 1;
    localparam int TIMEOUT = 50;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_active;
    logic          resp_done;
    logic          junk_done;
    logic          tx_done;
    logic          tick;
    logic          hash_en;
    logic          hash_clr;
    logic [8*HB-1:0] block;
    logic [31:0]   best_nonce;
    logic [1:0]    state;

    assign tx_done = resp_done | junk_done;

    miner_link_ctrl #(
        .HEADER_BYTES  (HB),
        .NONCE_BYTES   (NB),
        .HASH_TICKS    (TICKS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .rx_valid_i   (rx_valid),
        .rx_byte_i    (rx_byte),
        .tx_start_o   (tx_start),
        .tx_byte_o    (tx_byte),
        .tx_active_i  (tx_active),
        .tx_done_i    (tx_done),
        .second_tick_i(tick),
        .hash_enable_o(hash_en),
        .hash_clear_o (hash_clr),
        .block_o      (block),
        .best_nonce_i (best_nonce),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]      tx_q[$];
    logic [8*HB-1:0] blk_q[$];
    logic [8*HB-1:0] exp_block = '0;
    int              exp_cnt   = 0;
    int              jobs_done = 0;
    int              clear_cnt = 0;
    int              dones     = 0;
    logic            tx_busy   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_blk(input string nm, input logic [8*HB-1:0] act, input logic [8*HB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (hash_clr) begin
            clear_cnt++;
            check("clear_pending", 64'(blk_q.size() > 0), 64'(1));
            if (blk_q.size() > 0) check_blk("block_at_hash", block, blk_q.pop_front());
        end
        if (tx_start) begin
            check("tx_overlap", 64'(tx_busy), 64'(0));
            check("tx_pending", 64'(tx_q.size() > 0), 64'(1));
            if (tx_q.size() > 0) check("tx_byte", 64'(tx_byte), 64'(tx_q.pop_front()));
        end
    end

    // Emulated UART transmitter
    initial begin
        tx_active = 1'b0;
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk); #1;
                tx_busy   = 1'b1;
                tx_active = 1'b1;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1;
                tx_active = 1'b0;
                resp_done = 1'b1;
                @(posedge clk); #1;
                resp_done = 1'b0;
                tx_busy   = 1'b0;
                dones++;
                if (tx_q.size() == 0) check("recv_after_last_done", 64'(state), 64'(0));
                else                  check("start_after_done", 64'(tx_start), 64'(1));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        if (exp_cnt > 0 && gap >= TIMEOUT) exp_cnt = 0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        exp_block[8*exp_cnt +: 8] = b;
        exp_cnt++;
        if (exp_cnt == HB) begin
            exp_cnt = 0;
            jobs_done++;
            blk_q.push_back(exp_block);
            check("state_hash", 64'(state), 64'(1));
            check("clear_first", 64'(hash_clr), 64'(1));
            check("en_first", 64'(hash_en), 64'(1));
            @(posedge clk); #1;
            check("clear_second", 64'(hash_clr), 64'(0));
            check("en_second", 64'(hash_en), 64'(1));
        end else begin
            check("state_recv", 64'(state), 64'(0));
        end
    endtask

    task automatic send_random_header();
        int start_jobs = jobs_done;
        int guard = 0;
        while (jobs_done == start_jobs && guard < 400) begin
            int g = ($urandom_range(0, 99) < 3) ? 49 + $urandom_range(0, 1) : $urandom_range(0, 2);
            send_byte(8'($urandom), g);
            guard++;
        end
        check("header_guard", 64'(guard < 400), 64'(1));
    endtask

    task automatic run_hash(input logic [31:0] nonce);
        for (int t = 0; t < TICKS; t++) begin
            repeat ($urandom_range(2, 8)) begin
                rx_valid = 1'($urandom);
                rx_byte  = 8'($urandom);
                @(posedge clk); #1;
                check("en_in_hash", 64'(hash_en), 64'(1));
            end
            rx_valid   = 1'b0;
            best_nonce = (t == TICKS - 1) ? nonce : 32'($urandom);
            tick       = 1'b1;
            @(posedge clk); #1;
            tick       = 1'b0;
            best_nonce = 32'($urandom);
        end
        for (int i = 0; i < NB; i++) tx_q.push_back(8'(nonce >> (24 - 8 * i)));
        check("state_send", 64'(state), 64'(2));
        check("en_off", 64'(hash_en), 64'(0));
        check_blk("block_stable_hash", block, exp_block);
    endtask

    task automatic run_send(input bit rst_after2);
        int cyc = 0;
        int d0  = dones;
        while (state != 2'd0 && cyc < 400 && !(rst_after2 && dones - d0 >= 2)) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_byte  = 8'($urandom);
            tick     = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        rx_valid = 1'b0;
        tick     = 1'b0;
        check("send_guard", 64'(cyc < 400), 64'(1));
        if (rst_after2) begin
            @(negedge clk);
            @(posedge clk); #1;
            rst_i = 1'b0;
            tx_q.delete();
            @(posedge clk); #1;
            rst_i = 1'b1;
            exp_block = '0;
            exp_cnt   = 0;
            check("rst_state", 64'(state), 64'(0));
            check("rst_en", 64'(hash_en), 64'(0));
            check_blk("rst_block", block, exp_block);
            repeat (12) begin @(posedge clk); #1; end
            check("rst_no_start_state", 64'(state), 64'(0));
        end else begin
            check("send_dones", 64'(dones - d0), 64'(NB));
            check("end_state", 64'(state), 64'(0));
            check("end_tx_q", 64'(tx_q.size()), 64'(0));
            check_blk("block_after_job", block, exp_block);
        end
    endtask

    initial begin
        logic [8*HB-1:0] blk;
        rst_i      = 1'b0;
        rx_valid   = 1'b0;
        rx_byte    = '0;
        junk_done  = 1'b0;
        tick       = 1'b0;
        best_nonce = '0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("rst_tx_start", 64'(tx_start), 64'(0));
            check("rst_tx_byte", 64'(tx_byte), 64'(0));
            check("rst_hash_en", 64'(hash_en), 64'(0));
            check("rst_hash_clr", 64'(hash_clr), 64'(0));
            check("rst_state_o", 64'(state), 64'(0));
            check_blk("rst_block_o", block, '0);
            rx_valid   = 1'($urandom);
            rx_byte    = 8'($urandom);
            tick       = 1'($urandom);
            junk_done  = 1'($urandom);
            best_nonce = 32'($urandom);
        end
        rx_valid  = 1'b0;
        tick      = 1'b0;
        junk_done = 1'b0;
        rst_i     = 1'b1;
        @(posedge clk); #1;

        junk_done = 1'b1;
        @(posedge clk); #1;
        junk_done = 1'b0;
        @(posedge clk); #1;
        check("stray_done_state", 64'(state), 64'(0));
        check("stray_done_start", 64'(tx_start), 64'(0));

        for (int i = 0; i < HB; i++) send_byte(8'(i), 0);
        blk = block;
        check("hdr_byte0", 64'(blk[7:0]), 64'h00);
        check("hdr_byte75", 64'(blk[607:600]), 64'h4B);
        run_hash(32'hDEADBEEF);
        run_send(1'b0);

        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
        for (int i = 0; i < HB; i++) send_byte(8'(8'h80 + i), (i == 0) ? 60 : 0);
        blk = block;
        check("timeout_byte0", 64'(blk[7:0]), 64'h80);
        run_hash(32'($urandom));
        run_send(1'b0);

        for (int j = 0; j < 2; j++) begin
            send_random_header();
            run_hash(32'($urandom));
            run_send(1'b0);
        end

        send_random_header();
        run_hash(32'($urandom));
        run_send(1'b1);

        send_random_header();
        run_hash(32'($urandom));
        run_send(1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("clear_pulses", 64'(clear_cnt), 64'(jobs_done));
        check("blk_q_empty", 64'(blk_q.size()), 64'(0));
        check("tx_q_empty", 64'(tx_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/miner_link_ctrl.md
# miner_link_ctrl

Sequencer between the UART byte links, the hashcore and the one-second timer. Assembles a 76-byte block header from received bytes, runs the hashcore for a programmable number of timer ticks, snapshots the best nonce and transmits it MSB-first. Replaces ad-hoc glue at top level with a single registered state machine.

## Interface
- `HEADER_BYTES`, 76: header bytes per job.
- `NONCE_BYTES`, 4: nonce bytes transmitted.
- `HASH_TICKS`, 1: `second_tick_i` pulses per job, ≥1.
- `TIMEOUT_CYCLES`, 100_000_000: idle cycles that abort a partial header, ≥2.

Ports:
- `clk`  in  1  sole clock.
- `rst_i`  in  1  reset, synchronous, active-low.
- `rx_valid_i`  in  1  one-cycle pulse: `rx_byte_i` valid.
- `rx_byte_i`  in  8  received byte.
- `tx_start_o`  out  1  one-cycle pulse: launch `tx_byte_o`.
- `tx_byte_o`  out  8  byte to transmit, held stable until `tx_done_i`.
- `tx_active_i`  in  1  transmitter busy.
- `tx_done_i`  in  1  one-cycle pulse: byte finished.
- `second_tick_i`  in  1  one-cycle timer pulse.
- `hash_enable_o`  out  1  hashcore run enable.
- `hash_clear_o`  out  1  one-cycle pulse: clear hashcore best hash/nonce.
- `block_o`  out  8*HEADER_BYTES  assembled header.
- `best_nonce_i`  in  32  hashcore best nonce.
- `state_o`  out  2  current state (debug).

## Operation
- States: RECV(0), HASH(1), SEND(2). Reset → RECV.
- RECV: each `rx_valid_i` writes byte k (k = 0-based count) to `block_o[8k+7:8k]`; count increments. On byte HEADER_BYTES−1: count→0, next state HASH, `hash_clear_o` pulses the first HASH cycle.
- Inter-byte timeout: in RECV with count>0, idle counter increments each cycle without `rx_valid_i`, resets on each byte. When it reaches TIMEOUT_CYCLES, count→0; `block_o` retains stale bytes (overwritten by next job).
- HASH: `hash_enable_o`=1. Tick counter counts `second_tick_i`. On the HASH_TICKS-th tick: latch `best_nonce_i` into nonce shift register, `hash_enable_o` deasserts next cycle, state→SEND. `second_tick_i` coincident with `hash_clear_o` counts.
- SEND: byte index i from 0. When not waiting and `tx_active_i`=0: `tx_byte_o`=nonce[31−8i:24−8i], pulse `tx_start_o`, set waiting. On `tx_done_i`: clear waiting, i++. After NONCE_BYTES done pulses → RECV.
- `rx_valid_i` outside RECV: dropped. `tx_done_i` outside SEND or while not waiting: ignored. `second_tick_i` outside HASH: ignored.
- `block_o` is stable throughout HASH.

## Timing
- Reset values: `tx_start_o`=0, `tx_byte_o`=0, `hash_enable_o`=0, `hash_clear_o`=0, `block_o`=0, `state_o`=0; all counters 0.
- Reset mid-job: next edge returns to RECV, `hash_enable_o`=0; a UART byte in flight completes in the transmitter and its `tx_done_i` is ignored.
- Last header byte at cycle N → `state_o`=HASH, `hash_clear_o`=1, `hash_enable_o`=1 at N+1; `hash_clear_o`=0 at N+2.
- Final tick at cycle T → nonce latched at T; `state_o`=SEND, `hash_enable_o`=0 at T+1; first `tx_start_o` at T+2 earliest.
- `tx_done_i` at cycle D → next `tx_start_o` at D+1 earliest (if `tx_active_i`=0). Last done at D → `state_o`=RECV at D+1.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Shared package `miner_pkg`: `state_e` enum, `HEADER_BYTES`/`NONCE_BYTES` defaults, `NONCE_W`=32, `HASH_W`=256.
- Flat module; no sub-module. Timeout counter width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Reset: hold `rst_i`=0 with random inputs → all outputs 0, `state_o`=0; release → accepts first byte.
- Header load: bytes 0x00..0x4B back-to-back → `block_o[7:0]`=0x00, `block_o[607:600]`=0x4B, one `hash_clear_o` pulse, `hash_enable_o`=1.
- Report: HASH_TICKS=1, `best_nonce_i`=0xDEADBEEF, tick → `hash_enable_o` drops, tx bytes 0xDE, 0xAD, 0xBE, 0xEF in order, one start per done, `state_o`=0 after 4th done.
- Timeout (TIMEOUT_CYCLES=50): 10 bytes, 60-cycle gap, then 76 bytes 0x80.. → HASH entered only after 76th new byte, `block_o[7:0]`=0x80.
- Ignored traffic: `rx_valid_i` during HASH/SEND and stray `tx_done_i` in RECV → no state or `block_o` change.
- Reset mid-SEND after 2 bytes → RECV next edge, no further `tx_start_o`; subsequent job completes normally.
